id_stage: RTL and testbench

- MIPS pipeline decode stage: the consumer of the fetch stage's decoded fields (opcode, rs, rt, rd, immediate, func).
- Also the producer of the fetch stage's steering inputs: eq, jmp, beq, bne, PCwrite, awrite.
- Contains the 32x32 register file, control decoder, branch comparator, load-use/branch hazard detection and the ID/EX pipeline register.
- Sits between the fetch stage and the execute stage; takes writeback from the WB stage.

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/id_stage_regfile.sv | 40 ++++
 rtl/id_stage.sv | 191 +++++++++++++++++++
 tb/tb_id_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode definitions.
//   - opcode / func field constants for the supported instruction subset
//   - ALU operation encodings driven into the execute stage
//   - ex_ctrl layout: bit-position constants plus a packed struct view
package mips_pkg;

  localparam int NREG = 32;
  localparam int DW   = 32;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type func field values
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  // ex_ctrl bit positions (MSB first: reg_write ... spare[1:0])
  localparam int CTRL_W        = 10;
  localparam int CB_REG_WRITE  = 9;
  localparam int CB_MEM_READ   = 8;
  localparam int CB_MEM_WRITE  = 7;
  localparam int CB_MEM_TO_REG = 6;
  localparam int CB_ALU_SRC    = 5;
  localparam int CB_ALU_OP_HI  = 4;
  localparam int CB_ALU_OP_LO  = 2;

  // Packed view whose field order matches the bit positions above.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    alu_op_e    alu_op;
    logic [1:0] spare;
  } ex_ctrl_t;

endpackage

// File: rtl/id_stage_regfile.sv
// regfile: NREG x DW register file for the decode stage.
//   clk, rst        : clock, synchronous active-high reset (clears every entry)
//   ra1_i/rd1_o     : read port 1 (combinational)
//   ra2_i/rd2_o     : read port 2 (combinational)
//   we_i/wa_i/wd_i  : write port, committed on the rising edge
// Entry 0 always reads 0. A write in flight to the addressed entry is
// forwarded to the read port in the same cycle (write-through bypass).
module regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  ra1_i,
  input  logic [$clog2(NREG)-1:0]  ra2_i,
  output logic [DW-1:0]            rd1_o,
  output logic [DW-1:0]            rd2_o,
  input  logic                     we_i,
  input  logic [$clog2(NREG)-1:0]  wa_i,
  input  logic [DW-1:0]            wd_i
);

  logic [DW-1:0] mem_q [NREG];

  // NOTE: the whole array is cleared on reset, so it maps to flops rather than
  // a RAM macro; that is intended here so every register reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0)                ? '0   :
                 (we_i && (wa_i == ra1_i))    ? wd_i : mem_q[ra1_i];
  assign rd2_o = (ra2_i == '0)                ? '0   :
                 (we_i && (wa_i == ra2_i))    ? wd_i : mem_q[ra2_i];

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS pipeline decode stage.
//   Inputs : clk, rst (sync, active-high); decoded IF/ID fields opcode, rs, rt,
//            rd, immediate, func; writeback port wb_we/wb_addr/wb_data;
//            MEM-stage load info mem_mem_read/mem_dst.
//   Outputs: eq (bypassed rs==rt), jmp/beq/bne (suppressed on stall),
//            PCwrite/awrite (low = stall), ID/EX register ex_ctrl, ex_a,
//            ex_b, ex_imm, ex_dst.
// Optional: define ID_STALL_CNT_EN to add output stall_cnt, a saturating count
//           of stalled cycles cleared by rst.
module id_stage
  import mips_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    opcode,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   immediate,
  input  logic [5:0]    func,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          mem_mem_read,
  input  logic [4:0]    mem_dst,
  output logic          eq,
  output logic          jmp,
  output logic          beq,
  output logic          bne,
  output logic          PCwrite,
  output logic          awrite,
  output logic [9:0]    ex_ctrl,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_dst
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  logic [DW-1:0] rs_val, rt_val;

  regfile #(.NREG(NREG), .DW(DW)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rs_val),
    .rd2_o (rt_val),
    .we_i  (wb_we),
    .wa_i  (wb_addr),
    .wd_i  (wb_data)
  );

  // ---------------- decode ----------------
  ex_ctrl_t dec_ctrl;
  logic [4:0] dec_dst;
  logic use_rs, use_rt, is_beq, is_bne, is_jump, r_ok;
  alu_op_e r_op;

  // NOTE: every signal gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    dec_ctrl = '0;
    dec_dst  = '0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_jump  = 1'b0;
    r_ok     = 1'b0;
    r_op     = ALU_ADD;
    case (func)
      FN_ADD:  begin r_ok = 1'b1; r_op = ALU_ADD; end
      FN_SUB:  begin r_ok = 1'b1; r_op = ALU_SUB; end
      FN_AND:  begin r_ok = 1'b1; r_op = ALU_AND; end
      FN_OR:   begin r_ok = 1'b1; r_op = ALU_OR;  end
      FN_SLT:  begin r_ok = 1'b1; r_op = ALU_SLT; end
      default: ;
    endcase
    case (opcode)
      OP_RTYPE: begin
        // An unknown func stays a NOP that reads nothing, so a flushed
        // IF/ID (all zero) never triggers a hazard.
        if (r_ok) begin
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.alu_op    = r_op;
          dec_dst            = rd;
          use_rs             = 1'b1;
          use_rt             = 1'b1;
        end
      end
      OP_LW: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_dst             = rt;
        use_rs              = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        use_rs             = 1'b1;
        use_rt             = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_dst            = rt;
        use_rs             = 1'b1;
      end
      OP_BEQ: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_J:   is_jump = 1'b1;
      default: ;
    endcase
  end

  // ---------------- hazard detection ----------------
  ex_ctrl_t ex_ctrl_q, ex_ctrl_d;
  logic [4:0] ex_dst_q, ex_dst_d;
  logic [DW-1:0] ex_a_q, ex_b_q, ex_imm_q;
  logic is_branch, ex_hit_rs, ex_hit_rt, mem_hit, load_use, br_alu, br_load, stall;

  assign is_branch = is_beq | is_bne;
  assign ex_hit_rs = (ex_dst_q != '0) && (ex_dst_q == rs);
  assign ex_hit_rt = (ex_dst_q != '0) && (ex_dst_q == rt);
  assign mem_hit   = (mem_dst != '0) && ((mem_dst == rs) || (mem_dst == rt));

  assign load_use = ex_ctrl_q.mem_read && ((use_rs && ex_hit_rs) || (use_rt && ex_hit_rt));
  // A branch resolves in ID, so any result still in EX is too late to bypass.
  assign br_alu   = is_branch && ex_ctrl_q.reg_write && (ex_hit_rs || ex_hit_rt);
  assign br_load  = is_branch && mem_mem_read && mem_hit;
  assign stall    = load_use | br_alu | br_load;

  assign PCwrite = ~stall;
  assign awrite  = ~stall;
  assign jmp     = is_jump & ~stall;
  assign beq     = is_beq  & ~stall;
  assign bne     = is_bne  & ~stall;
  assign eq      = (rs_val == rt_val);

  // ---------------- ID/EX register ----------------
  // A stall inserts a bubble: no control and no destination.
  assign ex_ctrl_d = stall ? '0 : dec_ctrl;
  assign ex_dst_d  = stall ? '0 : dec_dst;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q <= '0;
      ex_dst_q  <= '0;
      ex_a_q    <= '0;
      ex_b_q    <= '0;
      ex_imm_q  <= '0;
    end else begin
      ex_ctrl_q <= ex_ctrl_d;
      ex_dst_q  <= ex_dst_d;
      ex_a_q    <= rs_val;
      ex_b_q    <= rt_val;
      ex_imm_q  <= {{(DW-16){immediate[15]}}, immediate};
    end
  end

  assign ex_ctrl = ex_ctrl_q;
  assign ex_dst  = ex_dst_q;
  assign ex_a    = ex_a_q;
  assign ex_b    = ex_b_q;
  assign ex_imm  = ex_imm_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage. A behavioural model (register
// array, decode table, hazard rules) predicts every output each cycle; directed
// sequences add literal expectations, then randomized traffic follows.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_mem_read;
  logic [4:0]  mem_dst;
  logic        eq, jmp, beq, bne, PCwrite, awrite;
  logic [9:0]  ex_ctrl;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [4:0]  ex_dst;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial forever #5 clk = ~clk;

  id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .immediate    (immediate),
    .func         (func),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .mem_mem_read (mem_mem_read),
    .mem_dst      (mem_dst),
    .eq           (eq),
    .jmp          (jmp),
    .beq          (beq),
    .bne          (bne),
    .PCwrite      (PCwrite),
    .awrite       (awrite),
    .ex_ctrl      (ex_ctrl),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .ex_imm       (ex_imm),
    .ex_dst       (ex_dst)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  logic [9:0]  m_ctrl;
  logic [4:0]  m_dst;
  logic [31:0] m_a, m_b, m_imm, m_cnt;
  bit          m_data_ok;
  bit          model_on = 1'b0;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  // ex_ctrl word: reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[2:0], 2'b00
  function automatic logic [9:0] pack(input bit rw, mr, mw, m2r, as, input int aluop);
    return {rw, mr, mw, m2r, as, 3'(aluop), 2'b00};
  endfunction

  typedef struct {
    logic [9:0] ctrl;
    logic [4:0] dst;
    bit urs, urt, br, jp;
  } dec_t;

  function automatic dec_t m_decode();
    dec_t d;
    d = '{ctrl: 10'd0, dst: 5'd0, urs: 1'b0, urt: 1'b0, br: 1'b0, jp: 1'b0};
    case (int'(opcode))
      0: if (int'(func) inside {32, 34, 36, 37, 42}) begin
           d.ctrl = pack(1, 0, 0, 0, 0, (func == 6'd32) ? 0 : (func == 6'd34) ? 1 :
                                        (func == 6'd36) ? 2 : (func == 6'd37) ? 3 : 4);
           d.dst = rd; d.urs = 1'b1; d.urt = 1'b1;
         end
      35: begin d.ctrl = pack(1, 1, 0, 1, 1, 0); d.dst = rt; d.urs = 1'b1; end
      43: begin d.ctrl = pack(0, 0, 1, 0, 1, 0); d.urs = 1'b1; d.urt = 1'b1; end
      8:  begin d.ctrl = pack(1, 0, 0, 0, 1, 0); d.dst = rt; d.urs = 1'b1; end
      4, 5: begin d.br = 1'b1; d.urs = 1'b1; d.urt = 1'b1; end
      2:  d.jp = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  function automatic bit m_stall(input dec_t d);
    bit ex_rs, ex_rt, a, b, c;
    ex_rs = (m_dst != 0) && (m_dst == rs);
    ex_rt = (m_dst != 0) && (m_dst == rt);
    a = m_ctrl[8] && ((d.urs && ex_rs) || (d.urt && ex_rt));
    b = d.br && m_ctrl[9] && (ex_rs || ex_rt);
    c = d.br && mem_mem_read && (mem_dst != 0) && (mem_dst == rs || mem_dst == rt);
    return a || b || c;
  endfunction

  // State update at each rising edge.
  initial forever begin
    dec_t d;
    bit st;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_ctrl = 10'd0; m_dst = 5'd0; m_a = 0; m_b = 0; m_imm = 0; m_cnt = 0;
      m_data_ok = 1'b1;
      model_on = 1'b1;
    end else if (model_on) begin
      d  = m_decode();
      st = m_stall(d);
      m_a   = m_read(rs);
      m_b   = m_read(rt);
      m_imm = 32'($signed(immediate));
      if (st) begin
        m_ctrl = 10'd0; m_dst = 5'd0; m_data_ok = 1'b0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else begin
        m_ctrl = d.ctrl; m_dst = d.dst; m_data_ok = 1'b1;
      end
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
    end
  end

  // Compare every output on the falling edge.
  initial forever begin
    dec_t d;
    bit st;
    @(negedge clk);
    if (model_on) begin
      d  = m_decode();
      st = m_stall(d);
      check("m_PCwrite", 32'(PCwrite), 32'(!st));
      check("m_awrite",  32'(awrite),  32'(!st));
      check("m_jmp",     32'(jmp),     32'(d.jp && !st));
      check("m_beq",     32'(beq),     32'(d.br && opcode == 6'd4 && !st));
      check("m_bne",     32'(bne),     32'(d.br && opcode == 6'd5 && !st));
      check("m_eq",      32'(eq),      32'(m_read(rs) == m_read(rt)));
      check("m_ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
      check("m_ex_dst",  32'(ex_dst),  32'(m_dst));
      if (m_data_ok) begin
        check("m_ex_a",   ex_a,   m_a);
        check("m_ex_b",   ex_b,   m_b);
        check("m_ex_imm", ex_imm, m_imm);
      end
`ifdef ID_STALL_CNT_EN
      check("m_stall_cnt", stall_cnt, m_cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input int op, input int s, input int t, input int d, input int imm, input int fn);
    opcode = 6'(op); rs = 5'(s); rt = 5'(t); rd = 5'(d); immediate = 16'(imm); func = 6'(fn);
  endtask

  initial begin
    logic [5:0] fns [5];
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    rst = 1'b1;
    instr(0, 0, 0, 0, 0, 0);
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    mem_mem_read = 1'b0; mem_dst = 5'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("rst_ex_a", ex_a, 32'h0);

    // addi $1,$0,5
    instr(8, 0, 1, 0, 5, 0); #2;
    check("addi_pcwrite", 32'(PCwrite), 32'h1);
    check("addi_awrite", 32'(awrite), 32'h1);
    tick();
    check("addi_ctrl", 32'(ex_ctrl), 32'h220);
    check("addi_imm", ex_imm, 32'h5);
    check("addi_dst", 32'(ex_dst), 32'h1);

    // write-through bypass: add $4,$3,$0 while $3 is being written
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    instr(0, 3, 0, 4, 0, 32);
    tick();
    check("bypass_ex_a", ex_a, 32'hDEAD_BEEF);
    check("add_ctrl", 32'(ex_ctrl), 32'h200);
    check("add_dst", 32'(ex_dst), 32'h4);

    // write to r0 is dropped: add $4,$0,$3
    wb_addr = 5'd0; wb_data = 32'h1234_5678;
    instr(0, 0, 3, 4, 0, 32); #2;
    check("r0_eq", 32'(eq), 32'h0);
    tick();
    check("r0_ex_a", ex_a, 32'h0);
    check("r3_ex_b", ex_b, 32'hDEAD_BEEF);

    // lw $2 then add $5,$2,$2 -> one stall
    wb_we = 1'b0;
    instr(35, 0, 2, 0, 0, 0);
    tick();
    check("lw_ctrl", 32'(ex_ctrl), 32'h360);
    check("lw_dst", 32'(ex_dst), 32'h2);
    instr(0, 2, 2, 5, 0, 32); #2;
    check("lu_pcwrite", 32'(PCwrite), 32'h0);
    check("lu_awrite", 32'(awrite), 32'h0);
    tick();
    check("lu_bubble", 32'(ex_ctrl), 32'h0);
    check("lu_bubble_dst", 32'(ex_dst), 32'h0);
    mem_mem_read = 1'b1; mem_dst = 5'd2; #2;
    check("lu_release", 32'(PCwrite), 32'h1);
    tick();
    check("lu_add_ctrl", 32'(ex_ctrl), 32'h200);
    check("lu_add_dst", 32'(ex_dst), 32'h5);

    // addi $6 then beq $6,$6 -> one stall
    mem_mem_read = 1'b0; mem_dst = 5'd0;
    instr(8, 0, 6, 0, 7, 0);
    tick();
    instr(4, 6, 6, 0, 0, 0); #2;
    check("ab_beq_stall", 32'(beq), 32'h0);
    check("ab_pcwrite", 32'(PCwrite), 32'h0);
    tick(); #2;
    check("ab_beq", 32'(beq), 32'h1);
    check("ab_eq", 32'(eq), 32'h1);
    tick();

    // lw $7 then beq $7,$0 -> two stalls, then resolves on the bypassed value
    instr(35, 0, 7, 0, 0, 0);
    tick();
    instr(4, 7, 0, 0, 0, 0); #2;
    check("lb_stall1", 32'(beq), 32'h0);
    tick();
    mem_mem_read = 1'b1; mem_dst = 5'd7; #2;
    check("lb_stall2", 32'(beq), 32'h0);
    check("lb_stall2_pc", 32'(PCwrite), 32'h0);
    tick();
    mem_mem_read = 1'b0; mem_dst = 5'd0;
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55; #2;
    check("lb_beq", 32'(beq), 32'h1);
    check("lb_eq", 32'(eq), 32'h0);
    check("lb_pcwrite", 32'(PCwrite), 32'h1);
    tick();
    wb_we = 1'b0;

    // j with a load to $9 in EX -> no stall
    instr(35, 0, 9, 0, 0, 0);
    tick();
    instr(2, 9, 9, 0, 16'h1234, 0); #2;
    check("j_jmp", 32'(jmp), 32'h1);
    check("j_pcwrite", 32'(PCwrite), 32'h1);
`ifdef ID_STALL_CNT_EN
    check("stall_cnt_4", stall_cnt, 32'd4);
`endif
    tick();

    // reset in the middle of a load-use stall
    instr(35, 0, 3, 0, 0, 0);
    tick();
    instr(0, 3, 3, 8, 0, 32); #2;
    check("mr_stall", 32'(PCwrite), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_ctrl", 32'(ex_ctrl), 32'h0);
    #2;
    check("mr_release", 32'(PCwrite), 32'h1);
    instr(0, 3, 0, 8, 0, 32); #2;
    check("mr_rf_cleared", 32'(eq), 32'h1);
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 9);
      instr(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 65535), 0);
      case (k)
        0, 1: func = fns[$urandom_range(0, 4)];
        2: opcode = 6'd35;
        3: opcode = 6'd43;
        4: opcode = 6'd8;
        5: opcode = 6'd4;
        6: opcode = 6'd5;
        7: opcode = 6'd2;
        8: instr(0, 0, 0, 0, 0, 0);
        default: opcode = 6'($urandom_range(9, 31));
      endcase
      wb_we        = 1'($urandom_range(0, 1));
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom());
      mem_mem_read = 1'($urandom_range(0, 1));
      mem_dst      = 5'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
